// File: rtl/fib_pkg.sv
// Shared constants, state encoding and helpers for the Fibonacci step sequencer.
package fib_pkg;

  localparam int          FIB_CLOCK_WIDTH = 6;
  localparam int          FIB_VAL_WIDTH   = 30;
  localparam logic [15:0] FIB_MAX_STEPS   = 16'd45;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } fib_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fib_step_sequencer_if.sv
// Control/status bundle linking wb_logic, the Fibonacci datapath and the step sequencer.
interface fib_step_sequencer_if
  import fib_pkg::*;
#(
  parameter int CLOCK_WIDTH = FIB_CLOCK_WIDTH,
  parameter int VAL_WIDTH   = FIB_VAL_WIDTH
);

  logic                   enable;
  logic [CLOCK_WIDTH-1:0] clock_op;
  logic                   restart;
  logic [VAL_WIDTH-1:0]   fib_val;
  logic                   fib_load;
  logic                   fib_step;
  logic [1:0]             state_o;
  logic [15:0]            step_count;
  logic                   done_irq;
  logic                   ovf_irq;

  modport master (
    output enable, clock_op, restart, fib_val,
    input  fib_load, fib_step, state_o, step_count, done_irq, ovf_irq
  );

  modport slave (
    input  enable, clock_op, restart, fib_val,
    output fib_load, fib_step, state_o, step_count, done_irq, ovf_irq
  );

endinterface

// File: rtl/fib_step_divider.sv
// Step-period divider: counts 0..clock_op and emits a one-cycle tick at the terminal count.
module fib_step_divider
  import fib_pkg::*;
#(
  parameter int CLOCK_WIDTH = FIB_CLOCK_WIDTH
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   freeze,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  output logic                   tick
);

  localparam logic [CLOCK_WIDTH-1:0] CNT_ONE = CLOCK_WIDTH'(1);

  logic [CLOCK_WIDTH-1:0] div_cnt_r;
  logic [CLOCK_WIDTH-1:0] div_cnt_nxt_s;
  logic                   tick_s;

  // Next count and tick; a terminal count landing in a freeze cycle is held and fires one cycle later.
  always_comb begin
    div_cnt_nxt_s = div_cnt_r;
    tick_s        = 1'b0;
    if (!en) begin
      div_cnt_nxt_s = '0;
    end else if (div_cnt_r > clock_op) begin
      div_cnt_nxt_s = '0;
    end else if (div_cnt_r == clock_op) begin
      if (freeze) begin
        div_cnt_nxt_s = div_cnt_r;
      end else begin
        div_cnt_nxt_s = '0;
        tick_s        = 1'b1;
      end
    end else begin
      div_cnt_nxt_s = div_cnt_r + CNT_ONE;
    end
  end

  // Divider count register.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/fib_step_sequencer.sv
// Sequences seed-load and step pulses for the Fibonacci datapath; tracks step count,
// detects datapath wrap-around and raises done/overflow interrupts.
module fib_step_sequencer
  import fib_pkg::*;
#(
  parameter int          CLOCK_WIDTH = FIB_CLOCK_WIDTH,
  parameter int          VAL_WIDTH   = FIB_VAL_WIDTH,
  parameter logic [15:0] MAX_STEPS   = FIB_MAX_STEPS
) (
  input logic                 wb_clk_i,
  input logic                 reset,
  fib_step_sequencer_if.slave bus
);

  fib_state_e           state_r;
  fib_state_e           state_nxt_s;
  logic [VAL_WIDTH-1:0] prev_val_r;
  logic [VAL_WIDTH-1:0] prev_val_nxt_s;
  logic [15:0]          step_count_r;
  logic [15:0]          step_count_nxt_s;
  logic                 fib_load_r;
  logic                 fib_step_r;
  logic                 cmp_pend_r;
  logic                 done_irq_r;
  logic                 ovf_irq_r;
  logic                 done_irq_nxt_s;
  logic                 ovf_irq_nxt_s;
  logic                 load_nxt_s;
  logic                 step_nxt_s;
  logic                 div_en_s;
  logic                 tick_s;
  logic                 cmp_cycle_s;
  logic                 ovf_hit_s;
  logic                 done_hit_s;

  assign div_en_s = (state_r == ST_LOAD) || (state_r == ST_RUN);

  // The cycle carrying fib_step is the one before the compare, so it freezes the divider.
  fib_step_divider #(
    .CLOCK_WIDTH (CLOCK_WIDTH)
  ) u_divider (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .en       (div_en_s),
    .freeze   (fib_step_r),
    .clock_op (bus.clock_op),
    .tick     (tick_s)
  );

  // Next-state and next-output logic; enable=0 overrides everything, then overflow, done, restart, step.
  always_comb begin
    cmp_cycle_s = (state_r == ST_RUN) && cmp_pend_r;
    ovf_hit_s   = cmp_cycle_s && (bus.fib_val < prev_val_r);
    done_hit_s  = cmp_cycle_s && !ovf_hit_s && (step_count_r == MAX_STEPS);
    state_nxt_s = state_r;
    if (!bus.enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_LOAD;
        ST_LOAD: state_nxt_s = ST_RUN;
        ST_RUN:  state_nxt_s = (ovf_hit_s || done_hit_s) ? ST_HALT : ST_RUN;
        ST_HALT: state_nxt_s = bus.restart ? ST_LOAD : ST_HALT;
        default: state_nxt_s = ST_IDLE;
      endcase
    end

    load_nxt_s = (state_nxt_s == ST_LOAD);
    step_nxt_s = tick_s && (state_nxt_s == ST_RUN);

    if (load_nxt_s) begin
      step_count_nxt_s = 16'd0;
    end else if (step_nxt_s) begin
      step_count_nxt_s = sat_inc16(step_count_r);
    end else begin
      step_count_nxt_s = step_count_r;
    end

    if (load_nxt_s || (state_nxt_s == ST_IDLE)) begin
      done_irq_nxt_s = 1'b0;
      ovf_irq_nxt_s  = 1'b0;
    end else begin
      done_irq_nxt_s = done_irq_r || done_hit_s;
      ovf_irq_nxt_s  = ovf_irq_r || ovf_hit_s;
    end

    if (load_nxt_s) begin
      prev_val_nxt_s = '0;
    end else if (cmp_cycle_s) begin
      prev_val_nxt_s = bus.fib_val;
    end else begin
      prev_val_nxt_s = prev_val_r;
    end
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      prev_val_r   <= '0;
      step_count_r <= 16'd0;
      fib_load_r   <= 1'b0;
      fib_step_r   <= 1'b0;
      cmp_pend_r   <= 1'b0;
      done_irq_r   <= 1'b0;
      ovf_irq_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_val_r   <= prev_val_nxt_s;
      step_count_r <= step_count_nxt_s;
      fib_load_r   <= load_nxt_s;
      fib_step_r   <= step_nxt_s;
      cmp_pend_r   <= fib_step_r;
      done_irq_r   <= done_irq_nxt_s;
      ovf_irq_r    <= ovf_irq_nxt_s;
    end
  end

  assign bus.fib_load   = fib_load_r;
  assign bus.fib_step   = fib_step_r;
  assign bus.state_o    = state_r;
  assign bus.step_count = step_count_r;
  assign bus.done_irq   = done_irq_r;
  assign bus.ovf_irq    = ovf_irq_r;

endmodule

// File: tb/tb_fib_step_sequencer.sv
// Self-checking bench: two sequencers (31-bit/45-step and 30-bit/60-step) share stimulus,
// each with a golden Fibonacci datapath and a pulse scoreboard.
module tb_fib_step_sequencer;
  import fib_pkg::*;

  typedef struct {
    bit is_load;
    int cyc;
    int cnt;
  } ev_t;

  logic       wb_clk_i = 1'b0;
  logic       reset;
  logic       enable;
  logic       restart;
  logic [5:0] clock_op;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  ev_t        q_a[$];
  ev_t        q_b[$];
  logic [30:0] fa_r, fb_r;
  logic [29:0] ga_r, gb_r;

  fib_step_sequencer_if #(.CLOCK_WIDTH(6), .VAL_WIDTH(31)) bus_a ();
  fib_step_sequencer_if #(.CLOCK_WIDTH(6), .VAL_WIDTH(30)) bus_b ();

  fib_step_sequencer #(.CLOCK_WIDTH(6), .VAL_WIDTH(31), .MAX_STEPS(16'd45)) dut_a (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .bus      (bus_a.slave)
  );

  fib_step_sequencer #(.CLOCK_WIDTH(6), .VAL_WIDTH(30), .MAX_STEPS(16'd60)) dut_b (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .bus      (bus_b.slave)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  assign bus_a.enable   = enable;
  assign bus_a.restart  = restart;
  assign bus_a.clock_op = clock_op;
  assign bus_a.fib_val  = fa_r;
  assign bus_b.enable   = enable;
  assign bus_b.restart  = restart;
  assign bus_b.clock_op = clock_op;
  assign bus_b.fib_val  = ga_r;

  // Golden datapaths: fib_val shows F(k) after k steps, wrapping at the datapath width.
  always @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      fa_r <= 31'd0; fb_r <= 31'd1;
    end else if (bus_a.fib_load) begin
      fa_r <= 31'd0; fb_r <= 31'd1;
    end else if (bus_a.fib_step) begin
      fa_r <= fb_r; fb_r <= fa_r + fb_r;
    end
  end

  always @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      ga_r <= 30'd0; gb_r <= 30'd1;
    end else if (bus_b.fib_load) begin
      ga_r <= 30'd0; gb_r <= 30'd1;
    end else if (bus_b.fib_step) begin
      ga_r <= gb_r; gb_r <= ga_r + gb_r;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input bit is_load, input int c, input int n);
    ev_t e;
    e.is_load = is_load;
    e.cyc     = c;
    e.cnt     = n;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  // Scoreboard for sequencer A: every load/step pulse must match the next expected event.
  always @(negedge wb_clk_i) begin
    ev_t e;
    if (bus_a.fib_load || bus_a.fib_step) begin
      check_val("a_ev_pending", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_val("a_ev_kind", 64'(bus_a.fib_load), 64'(e.is_load));
        check_val("a_ev_cycle", 64'(cyc), 64'(e.cyc));
        check_val("a_ev_count", 64'(bus_a.step_count), 64'(e.cnt));
      end
    end
  end

  // Scoreboard for sequencer B.
  always @(negedge wb_clk_i) begin
    ev_t e;
    if (bus_b.fib_load || bus_b.fib_step) begin
      check_val("b_ev_pending", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_val("b_ev_kind", 64'(bus_b.fib_load), 64'(e.is_load));
        check_val("b_ev_cycle", 64'(cyc), 64'(e.cyc));
        check_val("b_ev_count", 64'(bus_b.step_count), 64'(e.cnt));
      end
    end
  end

  // From IDLE at a negedge: clock_op=0 run until A reaches done and B overflows at step 45.
  task automatic run_c0();
    int t;
    t        = cyc;
    enable   = 1'b1;
    clock_op = 6'd0;
    push_ev(1'b1, t + 1, 0);
    for (int k = 1; k <= 45; k++) push_ev(1'b0, t + 2 * k, k);
    repeat (91) @(negedge wb_clk_i);
    check_val("a_state_compare", 64'(bus_a.state_o), 64'(ST_RUN));
    check_val("a_done_early", 64'(bus_a.done_irq), 64'd0);
    check_val("b_ovf_early", 64'(bus_b.ovf_irq), 64'd0);
    @(negedge wb_clk_i);
    check_val("a_state_halt", 64'(bus_a.state_o), 64'(ST_HALT));
    check_val("a_done_irq", 64'(bus_a.done_irq), 64'd1);
    check_val("a_ovf_irq", 64'(bus_a.ovf_irq), 64'd0);
    check_val("a_step_count", 64'(bus_a.step_count), 64'd45);
    check_val("a_fib_val", 64'(bus_a.fib_val), 64'd1134903170);
    check_val("b_state_halt", 64'(bus_b.state_o), 64'(ST_HALT));
    check_val("b_ovf_irq", 64'(bus_b.ovf_irq), 64'd1);
    check_val("b_done_irq", 64'(bus_b.done_irq), 64'd0);
    check_val("b_step_count", 64'(bus_b.step_count), 64'd45);
    check_val("b_fib_val", 64'(bus_b.fib_val), 64'd61161346);
    check_val("a_queue_empty", 64'(q_a.size()), 64'd0);
    check_val("b_queue_empty", 64'(q_b.size()), 64'd0);
  endtask

  initial begin
    int l;
    int r;
    reset    = 1'b1;
    enable   = 1'b1;
    restart  = 1'b0;
    clock_op = 6'd3;

    // Held in reset with a run request: everything stays quiet.
    repeat (5) begin
      @(negedge wb_clk_i);
      check_val("a_in_reset", 64'({bus_a.fib_load, bus_a.fib_step, bus_a.state_o,
                bus_a.step_count, bus_a.done_irq, bus_a.ovf_irq}), 64'd0);
    end
    reset = 1'b0;
    run_c0();

    // Restart together with enable low goes to IDLE without a load.
    enable  = 1'b0;
    restart = 1'b1;
    @(negedge wb_clk_i);
    restart = 1'b0;
    check_val("a_idle_state", 64'(bus_a.state_o), 64'(ST_IDLE));
    check_val("a_idle_done_clr", 64'(bus_a.done_irq), 64'd0);
    check_val("b_idle_state", 64'(bus_b.state_o), 64'(ST_IDLE));
    check_val("b_idle_ovf_clr", 64'(bus_b.ovf_irq), 64'd0);
    @(negedge wb_clk_i);
    check_val("a_idle_hold", 64'(bus_a.state_o), 64'(ST_IDLE));
    run_c0();

    // Restart from HALT with clock_op=5, then shrink clock_op to 2 while div_cnt=4.
    clock_op = 6'd5;
    restart  = 1'b1;
    l = cyc + 1;
    push_ev(1'b1, l, 0);
    push_ev(1'b0, l + 6, 1);
    push_ev(1'b0, l + 14, 2);
    push_ev(1'b0, l + 17, 3);
    push_ev(1'b0, l + 20, 4);
    @(negedge wb_clk_i);
    restart = 1'b0;
    check_val("a_restart_state", 64'(bus_a.state_o), 64'(ST_LOAD));
    check_val("a_restart_count", 64'(bus_a.step_count), 64'd0);
    check_val("a_restart_done", 64'(bus_a.done_irq), 64'd0);
    check_val("b_restart_ovf", 64'(bus_b.ovf_irq), 64'd0);
    @(negedge wb_clk_i);
    check_val("a_restart_run", 64'(bus_a.state_o), 64'(ST_RUN));
    repeat (9) @(negedge wb_clk_i);
    clock_op = 6'd2;
    repeat (2) @(negedge wb_clk_i);
    check_val("a_no_step_shrink", 64'(bus_a.fib_step), 64'd0);
    restart = 1'b1;
    @(negedge wb_clk_i);
    restart = 1'b0;
    repeat (9) @(negedge wb_clk_i);
    check_val("a_run_state", 64'(bus_a.state_o), 64'(ST_RUN));
    check_val("a_run_count", 64'(bus_a.step_count), 64'd4);
    check_val("a_queue_empty_run", 64'(q_a.size()), 64'd0);
    check_val("b_queue_empty_run", 64'(q_b.size()), 64'd0);

    // Asynchronous reset between steps clears the outputs before the next clock edge.
    #2 reset = 1'b1;
    #1;
    check_val("a_async_rst", 64'({bus_a.fib_load, bus_a.fib_step, bus_a.state_o,
              bus_a.step_count, bus_a.done_irq, bus_a.ovf_irq}), 64'd0);
    check_val("b_async_rst", 64'({bus_b.state_o, bus_b.step_count}), 64'd0);
    @(negedge wb_clk_i);
    check_val("a_rst_hold", 64'({bus_a.fib_step, bus_a.state_o, bus_a.step_count}), 64'd0);
    @(negedge wb_clk_i);
    reset = 1'b0;
    r = cyc;
    push_ev(1'b1, r + 1, 0);
    push_ev(1'b0, r + 4, 1);
    push_ev(1'b0, r + 7, 2);
    push_ev(1'b0, r + 10, 3);
    repeat (11) @(negedge wb_clk_i);
    check_val("a_post_rst_state", 64'(bus_a.state_o), 64'(ST_RUN));
    check_val("a_post_rst_count", 64'(bus_a.step_count), 64'd3);
    check_val("a_queue_empty_end", 64'(q_a.size()), 64'd0);
    check_val("b_queue_empty_end", 64'(q_b.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
